cpu_timer: RTL and testbench

CPU_TIMER -- requirements
Module: cpu_timer

---
 rtl/cpu_timer_if.sv | 22 ++
 rtl/cpu_timer.sv | 114 +++++++++++
 tb/tb_cpu_timer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_timer_if.sv
// CPU memory-bus view of the timer block: access controls, read data, hit flag and interrupt.
// The CPU drives through master; the timer sits on slave.
interface cpu_timer_if;
    logic [1:0]  t_cycle;
    logic        mem_enable;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_hit;
    logic        irq_timer;

    modport master (
        output t_cycle, mem_enable, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_hit, irq_timer
    );

    modport slave (
        input  t_cycle, mem_enable, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_hit, irq_timer
    );
endinterface

// File: rtl/cpu_timer.sv
// DIV/TIMA/TMA/TAC timer mapped at 0xFF04..0xFF07.
// A TIMA overflow opens a four-clock window reading 0x00, then reloads from TMA with a one-clock irq.
module cpu_timer (
    input  logic       clk,
    input  logic       reset_n,
    cpu_timer_if.slave bus
);
    // state   | meaning
    // IDLE    | TIMA counts falling edges of the selected DIV tap
    // PENDING | TIMA overflowed and reads 0x00; cnt_pend runs 3..0
    // RELOAD  | TIMA was just loaded from TMA; irq_timer high this clk
    typedef enum logic [1:0] {IDLE, PENDING, RELOAD} state_t;

    state_t      state;
    logic [1:0]  cnt_pend;
    logic [15:0] div;
    logic [7:0]  tima;
    logic [7:0]  tma;
    logic [2:0]  tac;
    logic        tick_q;
    logic        irq_q;
    logic        tap;
    logic        tick_in;
    logic        tick_fall;
    logic        wr_commit;
    logic        wr_div;
    logic        wr_tima;
    logic        wr_tma;
    logic        wr_tac;
    logic [7:0]  tma_eff;

    assign bus.mem_hit   = bus.mem_enable && (bus.mem_addr[15:2] == 14'h3FC1);
    assign wr_commit     = bus.mem_hit && bus.mem_write && (bus.t_cycle == 2'd3);
    assign wr_div        = wr_commit && (bus.mem_addr[1:0] == 2'd0);
    assign wr_tima       = wr_commit && (bus.mem_addr[1:0] == 2'd1);
    assign wr_tma        = wr_commit && (bus.mem_addr[1:0] == 2'd2);
    assign wr_tac        = wr_commit && (bus.mem_addr[1:0] == 2'd3);
    // A TMA write landing on the reload edge must reach TIMA in that same clock.
    assign tma_eff       = wr_tma ? bus.mem_wdata : tma;
    assign tick_in       = tap && tac[2];
    assign tick_fall     = tick_q && !tick_in;
    assign bus.irq_timer = irq_q;

    always_comb begin
        tap = div[9];
        case (tac[1:0])
            2'b00:   tap = div[9];
            2'b01:   tap = div[3];
            2'b10:   tap = div[5];
            default: tap = div[7];
        endcase
    end

    always_comb begin
        bus.mem_rdata = 8'hFF;
        if (bus.mem_hit) begin
            case (bus.mem_addr[1:0])
                2'd0:    bus.mem_rdata = div[15:8];
                2'd1:    bus.mem_rdata = tima;
                2'd2:    bus.mem_rdata = tma;
                default: bus.mem_rdata = {5'b11111, tac};
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div      <= 16'h0000;
            tima     <= 8'h00;
            tma      <= 8'h00;
            tac      <= 3'b000;
            tick_q   <= 1'b0;
            state    <= IDLE;
            cnt_pend <= 2'd0;
            irq_q    <= 1'b0;
        end else begin
            div    <= wr_div ? 16'h0000 : div + 16'd1;
            tick_q <= tick_in;
            irq_q  <= 1'b0;
            if (wr_tma) tma <= bus.mem_wdata;
            if (wr_tac) tac <= bus.mem_wdata[2:0];
            case (state)
                PENDING: begin
                    if (cnt_pend == 2'd0) begin
                        // Reload edge: any TIMA write or tick on this edge loses to TMA.
                        tima  <= tma_eff;
                        state <= RELOAD;
                        irq_q <= 1'b1;
                    end else if (wr_tima) begin
                        tima  <= bus.mem_wdata;
                        state <= IDLE;
                    end else begin
                        cnt_pend <= cnt_pend - 2'd1;
                        if (tick_fall) tima <= tima + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (wr_tima) begin
                        tima <= bus.mem_wdata;
                    end else if (tick_fall) begin
                        if (tima == 8'hFF) begin
                            tima     <= 8'h00;
                            state    <= PENDING;
                            cnt_pend <= 2'd3;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_timer.sv
// Scoreboard bench for cpu_timer: the driver pushes expected reads and irq cycles from a
// register-level reference model; a negedge monitor pops and compares what the DUT presents.
module tb_cpu_timer;
    logic clk = 1'b0;
    logic reset_n;

    cpu_timer_if bus();

    cpu_timer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    logic [8:0] rd_q[$];
    int         irq_q[$];
    logic [8:0] mon_e;
    bit         mon_irq;

    // Reference model: plain integers, overflow tracked as clocks remaining until reload.
    int m_div;
    int m_tima;
    int m_tma;
    int m_tac;
    int m_reload_in;
    bit m_prev_tick;

    function automatic void model_reset();
        m_div       = 0;
        m_tima      = 0;
        m_tma       = 0;
        m_tac       = 0;
        m_reload_in = -1;
        m_prev_tick = 1'b0;
        while (irq_q.size() > 0 && irq_q[irq_q.size()-1] >= cyc) void'(irq_q.pop_back());
    endfunction

    function automatic int model_read(logic [15:0] addr);
        if (addr < 16'hFF04 || addr > 16'hFF07) return 9'h0FF;
        if (addr == 16'hFF04) return 256 + (m_div / 256);
        if (addr == 16'hFF05) return 256 + m_tima;
        if (addr == 16'hFF06) return 256 + m_tma;
        return 256 + 248 + m_tac;
    endfunction

    function automatic void model_step();
        bit commit;
        bit tick_now;
        int tap_bit;
        int wd;
        commit = bus.mem_enable && bus.mem_write && (bus.t_cycle == 2'd3) &&
                 (bus.mem_addr >= 16'hFF04) && (bus.mem_addr <= 16'hFF07);
        wd = int'(bus.mem_wdata);
        case (m_tac % 4)
            0:       tap_bit = 9;
            1:       tap_bit = 3;
            2:       tap_bit = 5;
            default: tap_bit = 7;
        endcase
        tick_now = (((m_div >> tap_bit) % 2) == 1) && (m_tac >= 4);
        if (m_reload_in == 0) begin
            m_tima      = (commit && bus.mem_addr == 16'hFF06) ? wd : m_tma;
            m_reload_in = -1;
            irq_q.push_back(cyc);
        end else if (commit && bus.mem_addr == 16'hFF05) begin
            m_tima      = wd;
            m_reload_in = -1;
        end else begin
            if (m_reload_in > 0) m_reload_in--;
            if (m_prev_tick && !tick_now) begin
                if (m_tima == 255) begin
                    m_tima      = 0;
                    m_reload_in = 3;
                end else begin
                    m_tima++;
                end
            end
        end
        m_div = (commit && bus.mem_addr == 16'hFF04) ? 0 : (m_div + 1) % 65536;
        if (commit && bus.mem_addr == 16'hFF06) m_tma = wd;
        if (commit && bus.mem_addr == 16'hFF07) m_tac = wd % 8;
        m_prev_tick = tick_now;
    endfunction

    // One clock of stimulus; exp_v >= 0 pushes a fixed expected value for a hit read.
    task automatic drive(input bit rst_n, input bit en, input bit we, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [1:0] tc, input int exp_v);
        reset_n        = rst_n;
        bus.mem_enable = en;
        bus.mem_write  = we;
        bus.mem_addr   = addr;
        bus.mem_wdata  = wd;
        bus.t_cycle    = tc;
        if (!rst_n) model_reset();
        if (en && !we) begin
            if (exp_v >= 0) rd_q.push_back({1'b1, 8'(exp_v)});
            else            rd_q.push_back(9'(model_read(addr)));
        end
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        else       model_reset();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                  2'($urandom_range(0, 3)), -1);
    endtask

    task automatic rd(input logic [15:0] addr);
        drive(1'b1, 1'b1, 1'b0, addr, 8'($urandom), 2'($urandom_range(0, 3)), -1);
    endtask

    task automatic rd_exp(input logic [15:0] addr, input int v);
        drive(1'b1, 1'b1, 1'b0, addr, 8'($urandom), 2'($urandom_range(0, 3)), v);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] d);
        drive(1'b1, 1'b1, 1'b1, addr, d, 2'd3, -1);
    endtask

    task automatic wait_ovf();
        for (int i = 0; i < 2000; i++) begin
            if (m_reload_in == 3) break;
            rd(16'hFF05);
        end
    endtask

    task automatic wait_div3_high();
        for (int i = 0; i < 40; i++) begin
            if ((m_div % 16) == 12) break;
            idle(1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_enable && !bus.mem_write) begin
                n_tests++;
                if (rd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected addr=%h got hit=%b data=%h, nothing expected",
                             bus.mem_addr, bus.mem_hit, bus.mem_rdata);
                end else begin
                    mon_e = rd_q.pop_front();
                    if ({bus.mem_hit, bus.mem_rdata} !== mon_e) begin
                        n_fail++;
                        $display("FAIL rd addr=%h cyc=%0d got hit=%b data=%h, want hit=%b data=%h",
                                 bus.mem_addr, cyc, bus.mem_hit, bus.mem_rdata, mon_e[8], mon_e[7:0]);
                    end
                end
            end
            mon_irq = (irq_q.size() > 0) && (irq_q[0] == cyc);
            if (mon_irq) void'(irq_q.pop_front());
            n_tests++;
            if (bus.irq_timer !== mon_irq) begin
                n_fail++;
                $display("FAIL irq cyc=%0d got %b, want %b", cyc, bus.irq_timer, mon_irq);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [1:0]  s;
        int          r;
        int          v;

        reset_n        = 1'b0;
        bus.mem_enable = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = 16'h0000;
        bus.mem_wdata  = 8'h00;
        bus.t_cycle    = 2'd0;
        model_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reads during reset show reset values; a write during reset must not commit.
        drive(1'b0, 1'b1, 1'b0, 16'hFF07, 8'h00, 2'd1, 8'hF8);
        drive(1'b0, 1'b1, 1'b1, 16'hFF06, 8'h5A, 2'd3, -1);
        drive(1'b0, 1'b1, 1'b0, 16'hFF06, 8'h00, 2'd3, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 2'd0, -1);
        // Release mid-access with t_cycle=2: still no commit.
        drive(1'b1, 1'b1, 1'b1, 16'hFF06, 8'h77, 2'd2, -1);
        rd_exp(16'hFF06, 8'h00);
        idle(254);
        rd_exp(16'hFF04, 8'h01);

        for (int i = 0; i < 100 && m_div != 16'h0123; i++) idle(1);
        wr(16'hFF04, 8'h9C);
        rd_exp(16'hFF04, 8'h00);

        // div[3] tick rate
        wr(16'hFF07, 8'h05);
        wr(16'hFF05, 8'h00);
        for (int i = 0; i < 16; i++) begin
            idle(15);
            rd(16'hFF05);
        end

        // Overflow, pending window, reload with irq
        wr(16'hFF06, 8'hAB);
        wr(16'hFF05, 8'hFF);
        wait_ovf();
        for (int i = 0; i < 4; i++) rd_exp(16'hFF05, 8'h00);
        rd_exp(16'hFF05, 8'hAB);
        rd_exp(16'hFF05, 8'hAB);

        // TIMA write during the pending window cancels the reload
        wr(16'hFF05, 8'hFF);
        wait_ovf();
        rd_exp(16'hFF05, 8'h00);
        wr(16'hFF05, 8'h42);
        for (int i = 0; i < 6; i++) rd_exp(16'hFF05, 8'h42);

        // TMA written on the reload edge goes straight into TIMA
        wr(16'hFF05, 8'hFF);
        wait_ovf();
        idle(3);
        wr(16'hFF06, 8'h3C);
        rd_exp(16'hFF05, 8'h3C);
        // TIMA written on the reload edge is discarded
        wr(16'hFF05, 8'hFF);
        wait_ovf();
        idle(3);
        wr(16'hFF05, 8'h99);
        rd_exp(16'hFF05, 8'h3C);

        // Tick induced by a TAC change inside the pending window
        wr(16'hFF06, 8'hAB);
        wr(16'hFF05, 8'hFF);
        wait_ovf();
        if (((m_div >> 5) % 2) == 1)      s = 2'b10;
        else if (((m_div >> 7) % 2) == 1) s = 2'b11;
        else                              s = 2'b00;
        wr(16'hFF07, {5'b0, 1'b1, s});
        wr(16'hFF07, {6'b0, s});
        for (int i = 0; i < 6; i++) rd(16'hFF05);
        wr(16'hFF07, 8'h05);

        // DIV write and TAC disable produce falling edges
        wr(16'hFF05, 8'h10);
        wait_div3_high();
        v = m_tima;
        wr(16'hFF04, 8'h00);
        rd_exp(16'hFF05, v);
        rd_exp(16'hFF05, v + 1);
        wait_div3_high();
        v = m_tima;
        wr(16'hFF07, 8'h01);
        rd_exp(16'hFF05, v);
        rd_exp(16'hFF05, v + 1);

        // Reset during the pending window: no irq afterwards
        wr(16'hFF07, 8'h05);
        wr(16'hFF06, 8'h33);
        wr(16'hFF05, 8'hFF);
        wait_ovf();
        drive(1'b0, 1'b1, 1'b0, 16'hFF05, 8'h00, 2'd0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 16'hFF06, 8'h00, 2'd1, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 16'hFF07, 8'h00, 2'd2, 8'hF8);
        for (int i = 0; i < 10; i++) rd(16'hFF05);

        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 7))
                0:       a = 16'hFF03;
                1:       a = 16'hFF08;
                2:       a = 16'($urandom);
                default: a = 16'hFF04 + 16'($urandom_range(0, 3));
            endcase
            if (r < 30) begin
                idle(1);
            end else if (r < 60) begin
                rd(a);
            end else if (r < 82) begin
                drive(1'b1, 1'b1, 1'b1, a, 8'($urandom),
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'd3, -1);
            end else if (r < 98) begin
                wr(16'hFF05, 8'hFD + 8'($urandom_range(0, 2)));
            end else begin
                drive(1'b0, 1'b1, 1'b0, a, 8'h00, 2'd0, -1);
            end
        end
        idle(10);

        n_tests++;
        if (rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL rd_leftover got %0d unconsumed reads, want 0", rd_q.size());
        end
        n_tests++;
        if (irq_q.size() != 0) begin
            n_fail++;
            $display("FAIL irq_leftover got %0d missing irq pulses, want 0", irq_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
